// File: rtl/qeciphy_pkg.sv
// Shared types for the QECIPHY RX pattern checker.
package qeciphy_pkg;

  // Lock state of the RX pattern checker.
  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } chk_state_t;

endpackage

// File: rtl/qeciphy_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module qeciphy_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Clear has priority over increment; increment stops at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/qeciphy_rx_checker.sv
// Checks the QECIPHY RX stream against the incrementing-counter pattern from the TX source.
//
// state  | meaning
// HUNT   | no reference yet; next beat seeds it
// VERIFY | reference seeded; counting consecutive matches towards lock
// LOCKED | pattern locked; beats and mismatches are counted
module qeciphy_rx_checker
  import qeciphy_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int INCR      = 1,
  parameter int LOCK_GOOD = 8,
  parameter int LOSS_BAD  = 4,
  parameter int ERR_W     = 32,
  parameter int BEAT_W    = 48
) (
  input  logic              ACLK,
  input  logic              ARSTn,
  input  logic [DATA_W-1:0] RX_TDATA,
  input  logic              RX_TVALID,
  output logic              RX_TREADY,
  input  logic              clr,
  output logic              locked,
  output logic              err_sticky,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [BEAT_W-1:0] beat_cnt,
  output logic [DATA_W-1:0] first_err_exp,
  output logic [DATA_W-1:0] first_err_got
);

  localparam int GOOD_W = $clog2(LOCK_GOOD + 1);
  localparam int BAD_W  = $clog2(LOSS_BAD + 1);
  localparam logic [DATA_W-1:0] INCR_V    = DATA_W'(INCR);
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_GOOD - 1);
  localparam logic [BAD_W-1:0]  BAD_LAST  = BAD_W'(LOSS_BAD - 1);

  chk_state_t        state_q, state_d;
  logic [DATA_W-1:0] ref_q, ref_d;
  logic [GOOD_W-1:0] good_q, good_d;
  logic [BAD_W-1:0]  bad_q, bad_d;
  logic              tready_q;
  logic              sticky_q, sticky_d;
  logic [DATA_W-1:0] exp_q, exp_d;
  logic [DATA_W-1:0] got_q, got_d;
  logic              err_inc;
  logic              beat_inc;
  logic              match;

  assign match = (RX_TDATA == ref_q);

  // State, reference and run-length registers.
  always_ff @(posedge ACLK or negedge ARSTn) begin
    if (!ARSTn) begin
      state_q  <= HUNT;
      ref_q    <= '0;
      good_q   <= '0;
      bad_q    <= '0;
      tready_q <= 1'b0;
      sticky_q <= 1'b0;
      exp_q    <= '0;
      got_q    <= '0;
    end else begin
      state_q  <= state_d;
      ref_q    <= ref_d;
      good_q   <= good_d;
      bad_q    <= bad_d;
      tready_q <= 1'b1;
      sticky_q <= sticky_d;
      exp_q    <= exp_d;
      got_q    <= got_d;
    end
  end

  // Next-state: lock acquire/loss, reference tracking and count strobes.
  always_comb begin
    state_d  = state_q;
    ref_d    = ref_q;
    good_d   = good_q;
    bad_d    = bad_q;
    err_inc  = 1'b0;
    beat_inc = 1'b0;
    if (RX_TVALID) begin
      unique case (state_q)
        HUNT: begin
          ref_d   = RX_TDATA + INCR_V;
          good_d  = '0;
          state_d = VERIFY;
        end
        VERIFY: begin
          if (match) begin
            ref_d  = ref_q + INCR_V;
            good_d = good_q + 1'b1;
            if (good_q == GOOD_LAST) begin
              state_d = LOCKED;
              bad_d   = '0;
            end
          end else begin
            ref_d  = RX_TDATA + INCR_V;
            good_d = '0;
          end
        end
        LOCKED: begin
          beat_inc = 1'b1;
          ref_d    = ref_q + INCR_V;
          if (match) begin
            bad_d = '0;
          end else begin
            err_inc = 1'b1;
            bad_d   = bad_q + 1'b1;
            if (bad_q == BAD_LAST) state_d = HUNT;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // Sticky flag and first-error capture; clr overrides a coincident mismatch.
  always_comb begin
    sticky_d = sticky_q;
    exp_d    = exp_q;
    got_d    = got_q;
    if (clr) begin
      sticky_d = 1'b0;
      exp_d    = '0;
      got_d    = '0;
    end else if (err_inc) begin
      sticky_d = 1'b1;
      if (!sticky_q) begin
        exp_d = ref_q;
        got_d = RX_TDATA;
      end
    end
  end

  // Outputs decoded from registered state.
  always_comb begin
    locked        = (state_q == LOCKED);
    RX_TREADY     = tready_q;
    err_sticky    = sticky_q;
    first_err_exp = exp_q;
    first_err_got = got_q;
  end

  qeciphy_sat_counter #(.W(ERR_W)) u_err_cnt (
    .clk   (ACLK),
    .rst_n (ARSTn),
    .inc_i (err_inc),
    .clr_i (clr),
    .cnt_o (err_cnt)
  );

  qeciphy_sat_counter #(.W(BEAT_W)) u_beat_cnt (
    .clk   (ACLK),
    .rst_n (ARSTn),
    .inc_i (beat_inc),
    .clr_i (clr),
    .cnt_o (beat_cnt)
  );

endmodule

// File: tb/tb_qeciphy_rx_checker.sv
// Directed bench for the QECIPHY RX pattern checker.
module tb_qeciphy_rx_checker;

  logic        ACLK = 1'b0;
  logic        ARSTn = 1'b0;
  logic [63:0] RX_TDATA = '0;
  logic        RX_TVALID = 1'b0;
  logic        RX_TREADY;
  logic        clr = 1'b0;
  logic        locked;
  logic        err_sticky;
  logic [31:0] err_cnt;
  logic [47:0] beat_cnt;
  logic [63:0] first_err_exp;
  logic [63:0] first_err_got;

  int vectors = 0;
  int miscompares = 0;

  always #5 ACLK = ~ACLK;

  qeciphy_rx_checker dut (
    .ACLK          (ACLK),
    .ARSTn         (ARSTn),
    .RX_TDATA      (RX_TDATA),
    .RX_TVALID     (RX_TVALID),
    .RX_TREADY     (RX_TREADY),
    .clr           (clr),
    .locked        (locked),
    .err_sticky    (err_sticky),
    .err_cnt       (err_cnt),
    .beat_cnt      (beat_cnt),
    .first_err_exp (first_err_exp),
    .first_err_got (first_err_got)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs; returns 1 ns after the edge that consumed them.
  task automatic step(input logic v, input logic [63:0] d, input logic c);
    RX_TVALID = v;
    RX_TDATA  = d;
    clr       = c;
    @(posedge ACLK);
    #1;
    RX_TVALID = 1'b0;
    clr       = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tready"}, {63'd0, RX_TREADY}, 64'd0);
    check({tag, "_locked"}, {63'd0, locked}, 64'd0);
    check({tag, "_sticky"}, {63'd0, err_sticky}, 64'd0);
    check({tag, "_err"}, {32'd0, err_cnt}, 64'd0);
    check({tag, "_beat"}, {16'd0, beat_cnt}, 64'd0);
    check({tag, "_fexp"}, first_err_exp, 64'd0);
    check({tag, "_fgot"}, first_err_got, 64'd0);
  endtask

  initial begin
    logic [63:0] cur;
    int          nvalid;

    // Reset state
    #12;
    check_all_zero("rst");
    ARSTn = 1'b1;
    step(1'b0, 64'd0, 1'b0);
    check("tready_up", {63'd0, RX_TREADY}, 64'd1);
    check("idle_locked", {63'd0, locked}, 64'd0);

    // 1: seed 100, matches 101..108 lock after the ninth beat
    for (int i = 100; i <= 107; i++) step(1'b1, 64'(i), 1'b0);
    check("t1_not_yet", {63'd0, locked}, 64'd0);
    step(1'b1, 64'd108, 1'b0);
    check("t1_locked", {63'd0, locked}, 64'd1);
    check("t1_beat0", {16'd0, beat_cnt}, 64'd0);
    check("t1_err0", {32'd0, err_cnt}, 64'd0);
    step(1'b1, 64'd109, 1'b0);
    check("t1_beat1", {16'd0, beat_cnt}, 64'd1);
    // idle cycle changes nothing
    step(1'b0, 64'h1234, 1'b0);
    check("t1_idle_beat", {16'd0, beat_cnt}, 64'd1);

    // 2: single error in place of 200
    for (int i = 110; i <= 199; i++) step(1'b1, 64'(i), 1'b0);
    step(1'b1, 64'hDEAD, 1'b0);
    check("t2_err", {32'd0, err_cnt}, 64'd1);
    check("t2_sticky", {63'd0, err_sticky}, 64'd1);
    check("t2_fexp", first_err_exp, 64'd200);
    check("t2_fgot", first_err_got, 64'hDEAD);
    check("t2_locked", {63'd0, locked}, 64'd1);
    step(1'b1, 64'd201, 1'b0);
    check("t2_err_hold", {32'd0, err_cnt}, 64'd1);
    check("t2_locked2", {63'd0, locked}, 64'd1);
    check("t2_beat", {16'd0, beat_cnt}, 64'd93);

    // 3: four garbage beats drop lock; first-error capture is held
    step(1'b1, 64'h5555, 1'b0);
    step(1'b1, 64'h6666, 1'b0);
    step(1'b1, 64'h7777, 1'b0);
    check("t3_still_locked", {63'd0, locked}, 64'd1);
    step(1'b1, 64'h8888, 1'b0);
    check("t3_lost", {63'd0, locked}, 64'd0);
    check("t3_err", {32'd0, err_cnt}, 64'd5);
    check("t3_fexp_held", first_err_exp, 64'd200);
    check("t3_fgot_held", first_err_got, 64'hDEAD);
    check("t3_beat", {16'd0, beat_cnt}, 64'd97);
    for (int i = 1000; i <= 1007; i++) step(1'b1, 64'(i), 1'b0);
    check("t3_relock_pending", {63'd0, locked}, 64'd0);
    step(1'b1, 64'd1008, 1'b0);
    check("t3_relocked", {63'd0, locked}, 64'd1);
    check("t3_err_nochg", {32'd0, err_cnt}, 64'd5);

    // Async reset mid-stream
    RX_TVALID = 1'b1;
    RX_TDATA  = 64'd1009;
    ARSTn = 1'b0;
    #1;
    check_all_zero("arst1");
    #3;
    RX_TVALID = 1'b0;
    ARSTn = 1'b1;

    // 4: lock just below 2**64 and run through zero
    cur = 64'hFFFF_FFFF_FFFF_FFF4;
    for (int i = 0; i < 9; i++) begin
      step(1'b1, cur, 1'b0);
      cur = cur + 64'd1;
    end
    check("t4_locked", {63'd0, locked}, 64'd1);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, cur, 1'b0);
      cur = cur + 64'd1;
    end
    check("t4_cur_wrapped", cur, 64'd3);
    check("t4_err", {32'd0, err_cnt}, 64'd0);
    check("t4_sticky", {63'd0, err_sticky}, 64'd0);
    check("t4_beat", {16'd0, beat_cnt}, 64'd6);
    check("t4_locked2", {63'd0, locked}, 64'd1);

    // 5: clr coincident with a mismatch; the miss still counts towards lock loss
    step(1'b1, 64'hBAD, 1'b1);
    check("t5_err", {32'd0, err_cnt}, 64'd0);
    check("t5_sticky", {63'd0, err_sticky}, 64'd0);
    check("t5_beat", {16'd0, beat_cnt}, 64'd0);
    check("t5_fexp", first_err_exp, 64'd0);
    step(1'b1, 64'hBAD2, 1'b0);
    check("t5_err2", {32'd0, err_cnt}, 64'd1);
    check("t5_sticky2", {63'd0, err_sticky}, 64'd1);
    check("t5_fexp2", first_err_exp, 64'd4);
    check("t5_fgot2", first_err_got, 64'hBAD2);
    step(1'b1, 64'hBAD3, 1'b0);
    check("t5_locked3", {63'd0, locked}, 64'd1);
    step(1'b1, 64'hBAD4, 1'b0);
    check("t5_lost4", {63'd0, locked}, 64'd0);
    check("t5_err4", {32'd0, err_cnt}, 64'd3);
    check("t5_beat4", {16'd0, beat_cnt}, 64'd3);

    // clr alone never touches lock state
    step(1'b0, 64'd0, 1'b1);
    check("clr_err", {32'd0, err_cnt}, 64'd0);
    check("clr_beat", {16'd0, beat_cnt}, 64'd0);
    check("clr_sticky", {63'd0, err_sticky}, 64'd0);

    // 6: random valid gaps with a continuous pattern
    cur = 64'd5000;
    for (int i = 0; i < 9; i++) begin
      step(1'b1, cur, 1'b0);
      cur = cur + 64'd1;
    end
    check("t6_locked", {63'd0, locked}, 64'd1);
    nvalid = 0;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        step(1'b1, cur, 1'b0);
        cur = cur + 64'd1;
        nvalid++;
      end else begin
        step(1'b0, ~cur, 1'b0);
      end
    end
    check("t6_beat", {16'd0, beat_cnt}, 64'(nvalid));
    check("t6_err", {32'd0, err_cnt}, 64'd0);
    check("t6_locked2", {63'd0, locked}, 64'd1);

    RX_TVALID = 1'b1;
    RX_TDATA  = cur;
    ARSTn = 1'b0;
    #1;
    check_all_zero("arst2");
    #3;
    RX_TVALID = 1'b0;
    ARSTn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, cur, 1'b0);
      cur = cur + 64'd1;
    end
    check("t6_relock_pending", {63'd0, locked}, 64'd0);
    check("t6_tready", {63'd0, RX_TREADY}, 64'd1);
    step(1'b1, cur, 1'b0);
    check("t6_relocked", {63'd0, locked}, 64'd1);
    check("t6_err_final", {32'd0, err_cnt}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
